// File: rtl/scb_pkg.sv
// Shared types, sizes and the per-cycle delta helper for the register scoreboard.
package scb_pkg;
  localparam int REG_NUM   = 32;
  localparam int REG_ADDRW = 5;
  localparam int CNT_W     = 2;
  localparam int TOT_W     = 3;

  typedef logic [CNT_W-1:0] scb_cnt_t;

  localparam scb_cnt_t CNT_MAX = '1;

  // Net change for one cycle: +1 for an issue, -1 for each retire or squash.
  function automatic logic signed [2:0] scb_delta(input logic inc,
                                                  input logic dec_w,
                                                  input logic dec_k);
    logic signed [2:0] d;
    d = $signed({2'b00, inc}) - $signed({2'b00, dec_w}) - $signed({2'b00, dec_k});
    return d;
  endfunction
endpackage

// File: rtl/scb_cnt.sv
// One saturating in-flight writer counter (up by 1, down by up to 2 per cycle).
// SCB_ERRCHK_EN adds an underflow flag for the sticky error logic in the top.
module scb_cnt
  import scb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec_w,
  input  logic dec_k,
  output logic is_zero,
  output logic is_max
`ifdef SCB_ERRCHK_EN
  ,
  output logic underflow
`endif
);

  scb_cnt_t                cnt_q;
  logic signed [2:0]       delta;
  logic signed [CNT_W+1:0] sum;

  // Sum is two bits wider so both -2 and MAX+1 are representable.
  always_comb begin
    delta = scb_delta(inc, dec_w, dec_k);
    sum   = $signed({2'b00, cnt_q}) + $signed({{(CNT_W-1){delta[2]}}, delta});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (sum[CNT_W+1]) begin
      cnt_q <= '0;
    end else if (sum[CNT_W]) begin
      cnt_q <= CNT_MAX;
    end else begin
      cnt_q <= sum[CNT_W-1:0];
    end
  end

  assign is_zero = (cnt_q == '0);
  assign is_max  = (cnt_q == CNT_MAX);

`ifdef SCB_ERRCHK_EN
  assign underflow = sum[CNT_W+1];
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register in-flight writer scoreboard: pending flags for IDU sources and overflow stall.
// SCB_ERRCHK_EN adds a sticky o_err for underflow or firing while stalled.
module reg_scoreboard
  import scb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_idu_fire,
  input  logic                 i_idu_rdwen,
  input  logic [REG_ADDRW-1:0] i_idu_rdid,
  input  logic [REG_ADDRW-1:0] i_idu_rs1id,
  input  logic [REG_ADDRW-1:0] i_idu_rs2id,
  input  logic                 i_exu_kill,
  input  logic                 i_exu_rdwen,
  input  logic [REG_ADDRW-1:0] i_exu_rdid,
  input  logic                 i_wbu_rdwen,
  input  logic [REG_ADDRW-1:0] i_wbu_rdid,
  output logic                 o_rs1_pending,
  output logic                 o_rs2_pending,
  output logic                 o_issue_stall,
  output logic [TOT_W-1:0]     o_inflight
`ifdef SCB_ERRCHK_EN
  ,
  output logic                 o_err
`endif
);

  logic inc_q, dec_w_q, dec_k_q;
  logic [REG_NUM-1:0] zero_vec, max_vec;

  assign inc_q   = i_idu_fire & i_idu_rdwen & (i_idu_rdid != '0);
  assign dec_w_q = i_wbu_rdwen & (i_wbu_rdid != '0);
  assign dec_k_q = i_exu_kill & i_exu_rdwen & (i_exu_rdid != '0);

  // x0 is hard-wired idle: always zero, never at max.
  assign zero_vec[0] = 1'b1;
  assign max_vec[0]  = 1'b0;

`ifdef SCB_ERRCHK_EN
  logic [REG_NUM-1:0] ufl_vec;
  assign ufl_vec[0] = 1'b0;
`endif

  for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
    scb_cnt u_cnt (
      .clk       (i_clk),
      .rst       (i_rst),
      .inc       (inc_q & (i_idu_rdid == REG_ADDRW'(r))),
      .dec_w     (dec_w_q & (i_wbu_rdid == REG_ADDRW'(r))),
      .dec_k     (dec_k_q & (i_exu_rdid == REG_ADDRW'(r))),
      .is_zero   (zero_vec[r]),
      .is_max    (max_vec[r])
`ifdef SCB_ERRCHK_EN
      ,
      .underflow (ufl_vec[r])
`endif
    );
  end

  assign o_rs1_pending = ~zero_vec[i_idu_rs1id];
  assign o_rs2_pending = ~zero_vec[i_idu_rs2id];

  // A retire or squash on the same rd frees a slot this cycle, so no stall.
  assign o_issue_stall = i_idu_rdwen & (i_idu_rdid != '0) & max_vec[i_idu_rdid]
                       & ~(dec_w_q & (i_wbu_rdid == i_idu_rdid))
                       & ~(dec_k_q & (i_exu_rdid == i_idu_rdid));

  logic signed [2:0]       tot_delta;
  logic signed [TOT_W+1:0] tot_sum;

  always_comb begin
    tot_delta = scb_delta(inc_q, dec_w_q, dec_k_q);
    tot_sum   = $signed({2'b00, o_inflight})
              + $signed({{(TOT_W-1){tot_delta[2]}}, tot_delta});
  end

  // Total count saturates at both ends rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_inflight <= '0;
    end else if (tot_sum[TOT_W+1]) begin
      o_inflight <= '0;
    end else if (tot_sum[TOT_W]) begin
      o_inflight <= '1;
    end else begin
      o_inflight <= tot_sum[TOT_W-1:0];
    end
  end

`ifdef SCB_ERRCHK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if ((|ufl_vec) | (i_idu_fire & o_issue_stall)) begin
      o_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; covers the SCB_ERRCHK_EN error flag when defined.
module tb_reg_scoreboard;
  import scb_pkg::*;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_idu_fire, i_idu_rdwen;
  logic [REG_ADDRW-1:0] i_idu_rdid, i_idu_rs1id, i_idu_rs2id;
  logic                 i_exu_kill, i_exu_rdwen;
  logic [REG_ADDRW-1:0] i_exu_rdid;
  logic                 i_wbu_rdwen;
  logic [REG_ADDRW-1:0] i_wbu_rdid;
  logic                 o_rs1_pending, o_rs2_pending, o_issue_stall;
  logic [TOT_W-1:0]     o_inflight;
`ifdef SCB_ERRCHK_EN
  logic                 o_err;
`endif

  int errors = 0;
  int checks = 0;

  reg_scoreboard dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_idu_fire    (i_idu_fire),
    .i_idu_rdwen   (i_idu_rdwen),
    .i_idu_rdid    (i_idu_rdid),
    .i_idu_rs1id   (i_idu_rs1id),
    .i_idu_rs2id   (i_idu_rs2id),
    .i_exu_kill    (i_exu_kill),
    .i_exu_rdwen   (i_exu_rdwen),
    .i_exu_rdid    (i_exu_rdid),
    .i_wbu_rdwen   (i_wbu_rdwen),
    .i_wbu_rdid    (i_wbu_rdid),
    .o_rs1_pending (o_rs1_pending),
    .o_rs2_pending (o_rs2_pending),
    .o_issue_stall (o_issue_stall),
    .o_inflight    (o_inflight)
`ifdef SCB_ERRCHK_EN
    ,
    .o_err         (o_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_idu_fire  = 1'b0;
    i_idu_rdwen = 1'b0;
    i_idu_rdid  = '0;
    i_exu_kill  = 1'b0;
    i_exu_rdwen = 1'b0;
    i_exu_rdid  = '0;
    i_wbu_rdwen = 1'b0;
    i_wbu_rdid  = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [REG_ADDRW-1:0] rd);
    idle();
    i_idu_fire  = 1'b1;
    i_idu_rdwen = 1'b1;
    i_idu_rdid  = rd;
    tick();
  endtask

  task automatic retire(input logic [REG_ADDRW-1:0] rd);
    idle();
    i_wbu_rdwen = 1'b1;
    i_wbu_rdid  = rd;
    tick();
  endtask

  initial begin
    idle();
    i_idu_rs1id = '0;
    i_idu_rs2id = '0;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    check_output("rst_inflight", o_inflight, 0);
    check_output("rst_stall", o_issue_stall, 0);
    check_output("rst_pend1", o_rs1_pending, 0);

    // rd=5 issue, pending seen next cycle, cleared the cycle after retire
    idle();
    i_idu_fire = 1'b1; i_idu_rdwen = 1'b1; i_idu_rdid = 5'd5; i_idu_rs1id = 5'd5;
    #1 check_output("pend_same_cycle", o_rs1_pending, 0);
    tick();
    idle();
    check_output("pend_rd5", o_rs1_pending, 1);
    check_output("infl_rd5", o_inflight, 1);
    i_wbu_rdwen = 1'b1; i_wbu_rdid = 5'd5;
    #1 check_output("pend_retire_cycle", o_rs1_pending, 1);
    tick();
    idle();
    check_output("pend_rd5_clr", o_rs1_pending, 0);
    check_output("infl_rd5_clr", o_inflight, 0);

    // rd=7 up to MAX, then stall and its release by a same-cycle retire
    i_idu_rs2id = 5'd7;
    issue(5'd7);
    issue(5'd7);
    issue(5'd7);
    check_output("infl_rd7_3", o_inflight, 3);
    check_output("pend2_rd7", o_rs2_pending, 1);
    idle();
    i_idu_rdwen = 1'b1; i_idu_rdid = 5'd7;
    #1 check_output("stall_rd7_max", o_issue_stall, 1);
    i_wbu_rdwen = 1'b1; i_wbu_rdid = 5'd7;
    #1 check_output("stall_rd7_wb", o_issue_stall, 0);
    i_idu_fire = 1'b1;
    tick();
    idle();
    check_output("infl_rd7_hold", o_inflight, 3);
    i_idu_rdwen = 1'b1; i_idu_rdid = 5'd7;
    #1 check_output("stall_rd7_still_max", o_issue_stall, 1);
    i_exu_kill = 1'b1; i_exu_rdwen = 1'b1; i_exu_rdid = 5'd7;
    #1 check_output("stall_rd7_kill", o_issue_stall, 0);
    retire(5'd7);
    idle();
    i_idu_rdwen = 1'b1; i_idu_rdid = 5'd7;
    #1 check_output("stall_rd7_cnt2", o_issue_stall, 0);
    retire(5'd7);
    retire(5'd7);
    idle();
    check_output("infl_rd7_drained", o_inflight, 0);
    check_output("pend2_rd7_clr", o_rs2_pending, 0);

    // rd=9 at count 2: issue + kill + retire together nets -1
    issue(5'd9);
    issue(5'd9);
    check_output("infl_rd9_2", o_inflight, 2);
    idle();
    i_idu_fire = 1'b1; i_idu_rdwen = 1'b1; i_idu_rdid = 5'd9;
    i_exu_kill = 1'b1; i_exu_rdwen = 1'b1; i_exu_rdid = 5'd9;
    i_wbu_rdwen = 1'b1; i_wbu_rdid = 5'd9;
    tick();
    idle();
    i_idu_rs1id = 5'd9;
    #1 check_output("infl_rd9_net", o_inflight, 1);
    check_output("pend_rd9_1", o_rs1_pending, 1);
    retire(5'd9);
    idle();
    check_output("pend_rd9_clr", o_rs1_pending, 0);
    check_output("infl_rd9_clr", o_inflight, 0);

    // x0 is never counted
    i_idu_rs1id = 5'd0;
    issue(5'd0);
    issue(5'd0);
    idle();
    i_idu_fire = 1'b1; i_idu_rdwen = 1'b1; i_idu_rdid = 5'd0;
    i_wbu_rdwen = 1'b1; i_wbu_rdid = 5'd0;
    #1 check_output("stall_x0", o_issue_stall, 0);
    tick();
    idle();
    check_output("infl_x0", o_inflight, 0);
    check_output("pend_x0", o_rs1_pending, 0);

    // Retire on an empty counter saturates at 0 (no wrap to MAX)
    retire(5'd3);
    idle();
    i_idu_rs1id = 5'd3;
    i_idu_rdwen = 1'b1; i_idu_rdid = 5'd3;
    #1 check_output("underflow_no_wrap", o_issue_stall, 0);
    check_output("underflow_pend", o_rs1_pending, 0);
    check_output("underflow_infl", o_inflight, 0);
`ifdef SCB_ERRCHK_EN
    check_output("err_set", o_err, 1);
    tick();
    tick();
    check_output("err_sticky", o_err, 1);
`endif

    // Total count saturates at 7 across eight distinct registers
    for (int r = 1; r <= 8; r++) issue(REG_ADDRW'(r));
    idle();
    check_output("infl_sat_max", o_inflight, 7);

    // Reset held two cycles during traffic clears everything
    i_idu_rs1id = 5'd5; i_idu_rs2id = 5'd6;
    i_rst = 1'b1;
    issue(5'd10);
    check_output("rst_mid_infl_1", o_inflight, 0);
    issue(5'd11);
    i_rst = 1'b0;
    idle();
    check_output("rst_mid_infl", o_inflight, 0);
    check_output("rst_mid_pend1", o_rs1_pending, 0);
    check_output("rst_mid_pend2", o_rs2_pending, 0);
`ifdef SCB_ERRCHK_EN
    check_output("err_cleared", o_err, 0);
`endif
    i_idu_rs1id = 5'd1;
    tick();
    check_output("rst_mid_pend_x1", o_rs1_pending, 0);
    issue(5'd1);
    idle();
    check_output("post_rst_issue", o_inflight, 1);
    check_output("post_rst_pend", o_rs1_pending, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
